// File: rtl/hex_word_printer_if.sv
// Requester and UART-byte signals of the hex word printer.
// The printer takes the slave side.
interface hex_word_printer_if;
  logic        req0_valid;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        busy;
  logic        grant;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, tx_ready,
    input  req0_ready, req1_ready, tx_valid, tx_data, busy, grant
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, tx_ready,
    output req0_ready, req1_ready, tx_valid, tx_data, busy, grant
  );
endinterface

// File: rtl/hex_word_printer.sv
// Round-robin arbiter plus sequencer that prints 32-bit words as uppercase hex ASCII,
// MSB nibble first, optionally followed by CR LF.
module hex_word_printer #(
  parameter int DIGITS  = 8,
  parameter bit NEWLINE = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  hex_word_printer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DIGIT, CR, LF} state_t;

  localparam logic [2:0] CNT_INIT = 3'(DIGITS - 1);

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ptr_q, ptr_d;
  logic        grant_q, grant_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        busy_q, busy_d;

  logic        idle;
  logic        sel;
  logic        accept;
  logic        tx_acc;
  logic [2:0]  cnt_m1;
  logic [31:0] sel_data;
  logic [3:0]  nib [8];

  function automatic logic [7:0] to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  for (genvar gi = 0; gi < 8; gi++) begin : g_nib
    assign nib[gi] = word_q[4*gi +: 4];
  end

  // ptr only matters on a tie; a lone valid requester always wins.
  assign idle            = (state_q == IDLE);
  assign sel             = bus.req1_valid & (~bus.req0_valid | ptr_q);
  assign bus.req0_ready  = idle & bus.req0_valid & ~sel;
  assign bus.req1_ready  = idle & bus.req1_valid & sel;
  assign accept          = bus.req0_ready | bus.req1_ready;
  assign sel_data        = sel ? bus.req1_data : bus.req0_data;
  assign tx_acc          = tx_valid_q & bus.tx_ready;
  assign cnt_m1          = cnt_q - 3'd1;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          word_d     = sel_data;
          grant_d    = sel;
          ptr_d      = ~sel;
          cnt_d      = CNT_INIT;
          state_d    = DIGIT;
          tx_valid_d = 1'b1;
          tx_data_d  = to_ascii(sel_data[4*(DIGITS-1) +: 4]);
        end
      end
      DIGIT: begin
        if (tx_acc) begin
          if (cnt_q != 3'd0) begin
            cnt_d     = cnt_m1;
            tx_data_d = to_ascii(nib[cnt_m1]);
          end else if (NEWLINE) begin
            state_d   = CR;
            tx_data_d = 8'h0D;
          end else begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
          end
        end
      end
      CR: begin
        if (tx_acc) begin
          state_d   = LF;
          tx_data_d = 8'h0A;
        end
      end
      LF: begin
        if (tx_acc) begin
          state_d    = IDLE;
          tx_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_q     <= 32'h0;
      cnt_q      <= 3'd0;
      ptr_q      <= 1'b0;
      grant_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = busy_q;
  assign bus.grant    = grant_q;
endmodule

// File: tb/tb_hex_word_printer.sv
// Directed bench for hex_word_printer: a byte-queue model checked every cycle,
// plus literal expectations for each scenario and a DIGITS=2/NEWLINE=0 instance.
module tb_hex_word_printer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hex_word_printer_if b();
  hex_word_printer_if b2();

  hex_word_printer dut (.clk(clk), .rst_n(rst_n), .bus(b));
  hex_word_printer #(.DIGITS(2), .NEWLINE(1'b0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] byte_q[$];
  int         byte_cyc[$];
  int         acc_id[$];
  int         acc_cyc[$];
  logic [7:0] log2[$];

  // Model: the bytes still owed for the current word; empty means IDLE.
  logic [7:0] m_q[$];
  logic       m_grant = 1'b0;
  logic       m_ptr = 1'b0;
  string      hexchars = "0123456789ABCDEF";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void push_word(input logic [31:0] w);
    for (int i = 7; i >= 0; i--) m_q.push_back(hexchars[int'((w >> (4*i)) & 32'hF)]);
    m_q.push_back(8'h0D);
    m_q.push_back(8'h0A);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst_n) begin
      if (b.tx_valid && b.tx_ready) begin
        byte_q.push_back(b.tx_data);
        byte_cyc.push_back(cyc);
      end
      if (b.req0_valid && b.req0_ready) begin acc_id.push_back(0); acc_cyc.push_back(cyc); end
      if (b.req1_valid && b.req1_ready) begin acc_id.push_back(1); acc_cyc.push_back(cyc); end
      if (b2.tx_valid && b2.tx_ready) log2.push_back(b2.tx_data);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_grant <= 1'b0;
      m_ptr   <= 1'b0;
    end else if (m_q.size() != 0) begin
      if (b.tx_ready) void'(m_q.pop_front());
    end else if (b.req1_valid && (!b.req0_valid || m_ptr)) begin
      m_grant <= 1'b1;
      m_ptr   <= 1'b0;
      push_word(b.req1_data);
    end else if (b.req0_valid) begin
      m_grant <= 1'b0;
      m_ptr   <= 1'b1;
      push_word(b.req0_data);
    end
  end

  always @(negedge clk) begin
    chk("cyc_tx_valid", b.tx_valid, m_q.size() != 0);
    chk("cyc_busy", b.busy, m_q.size() != 0);
    chk("cyc_grant", b.grant, m_grant);
    chk("cyc_req0_ready", b.req0_ready, (m_q.size() == 0) && b.req0_valid && (!b.req1_valid || !m_ptr));
    chk("cyc_req1_ready", b.req1_ready, (m_q.size() == 0) && b.req1_valid && (!b.req0_valid || m_ptr));
    if (m_q.size() != 0) chk("cyc_tx_data", b.tx_data, m_q[0]);
  end

  task automatic raise(input int id, input logic [31:0] w);
    if (id == 0) begin b.req0_valid = 1'b1; b.req0_data = w; end
    else begin b.req1_valid = 1'b1; b.req1_data = w; end
  endtask

  task automatic drop(input int id);
    if (id == 0) begin b.req0_valid = 1'b0; b.req0_data = 32'hFFFF_FFFF; end
    else begin b.req1_valid = 1'b0; b.req1_data = 32'hFFFF_FFFF; end
  endtask

  task automatic wait_ready(input int id);
    logic r;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      r = (id == 0) ? b.req0_ready : b.req1_ready;
      n++;
    end while (!r && n < 200);
    chk("accept_ready", r, 1'b1);
  endtask

  task automatic send(input int id, input logic [31:0] w);
    @(posedge clk); #1;
    raise(id, w);
    wait_ready(id);
    @(posedge clk); #1;
    drop(id);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (b.busy && n < 200);
    chk("idle_reached", b.busy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic chk_str(input string name, input int base, input string s);
    chk({name, "_count"}, byte_q.size() - base, s.len());
    for (int i = 0; i < s.len(); i++)
      if (base + i < byte_q.size()) chk({name, "_byte"}, byte_q[base + i], s[i]);
  endtask

  initial begin
    int base, ab, n;
    logic found;
    logic [7:0] e1[10];
    e1 = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    b.req0_valid = 0; b.req0_data = 0; b.req1_valid = 0; b.req1_data = 0; b.tx_ready = 1;
    b2.req0_valid = 0; b2.req0_data = 0; b2.req1_valid = 0; b2.req1_data = 0; b2.tx_ready = 1;

    // Reset values, then a single word with no backpressure.
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", b.tx_valid, 0);
    chk("rst_tx_data", b.tx_data, 8'h00);
    chk("rst_busy", b.busy, 0);
    chk("rst_grant", b.grant, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    base = byte_q.size(); ab = acc_cyc.size();
    send(0, 32'hDEADBEEF);
    wait_idle();
    chk("t1_count", byte_q.size() - base, 10);
    for (int i = 0; i < 10; i++) if (base + i < byte_q.size()) chk("t1_byte", byte_q[base + i], e1[i]);
    if (byte_q.size() >= base + 10) begin
      chk("t1_latency", byte_cyc[base] - acc_cyc[ab], 1);
      chk("t1_back_to_back", byte_cyc[base + 9] - byte_cyc[base], 9);
    end

    // Tie right after reset: requester 0 first, requester 1 right after LF.
    do_reset();
    base = byte_q.size(); ab = acc_id.size();
    raise(0, 32'h00000001);
    raise(1, 32'h0000ABCD);
    wait_ready(0);
    @(posedge clk); #1; drop(0);
    wait_ready(1);
    @(posedge clk); #1; drop(1);
    wait_idle();
    chk_str("t2", base, "00000001\r\n0000ABCD\r\n");
    chk("t2_acc_cnt", acc_id.size() - ab, 2);
    if (acc_id.size() >= ab + 2 && byte_q.size() >= base + 10) begin
      chk("t2_first_id", acc_id[ab], 0);
      chk("t2_second_id", acc_id[ab + 1], 1);
      chk("t2_second_after_lf", acc_cyc[ab + 1] - byte_cyc[base + 9], 1);
    end

    // Backpressure on the first byte and on CR.
    base = byte_q.size();
    send(0, 32'h12345678);
    b.tx_ready = 1'b0;
    repeat (3) begin
      @(negedge clk); chk("t3_hold_first", b.tx_data, 8'h31);
      @(posedge clk);
    end
    #1; b.tx_ready = 1'b1;
    n = 0; found = 1'b0;
    do begin
      @(negedge clk); n++;
      found = b.tx_valid && (b.tx_data == 8'h0D);
    end while (!found && n < 100);
    chk("t3_cr_seen", found, 1'b1);
    b.tx_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); @(negedge clk); chk("t3_hold_cr", b.tx_data, 8'h0D);
    end
    b.tx_ready = 1'b1;
    wait_idle();
    chk_str("t3", base, "12345678\r\n");

    // Continuous contention: grants alternate, one idle cycle between words.
    do_reset();
    base = byte_q.size(); ab = acc_id.size();
    @(posedge clk); #1;
    raise(0, 32'h11112222);
    raise(1, 32'h33334444);
    n = 0;
    for (int k = 0; k < 400 && n < 4; k++) begin
      @(negedge clk);
      if (b.req0_ready || b.req1_ready) n++;
    end
    chk("t4_accepts", n, 4);
    @(posedge clk); #1; drop(0); drop(1);
    wait_idle();
    chk_str("t4", base, "11112222\r\n33334444\r\n11112222\r\n33334444\r\n");
    chk("t4_acc_cnt", acc_id.size() - ab, 4);
    for (int k = 0; k < 4; k++) if (ab + k < acc_id.size()) chk("t4_grant_order", acc_id[ab + k], k % 2);
    for (int k = 1; k < 4; k++)
      if (byte_q.size() >= base + 40) chk("t4_gap", byte_cyc[base + 10*k] - byte_cyc[base + 10*k - 1], 2);

    // Reset during the 4th digit; the partial word must not resume.
    base = byte_q.size();
    send(1, 32'hCAFEF00D);
    n = 0;
    do begin @(negedge clk); n++; end while (byte_q.size() < base + 3 && n < 100);
    chk("t5_before_reset", b.tx_data, 8'h45);
    #2; rst_n = 1'b0;
    #1;
    chk("t5_async_tx_valid", b.tx_valid, 0);
    chk("t5_async_tx_data", b.tx_data, 8'h00);
    chk("t5_async_busy", b.busy, 0);
    chk("t5_async_grant", b.grant, 0);
    @(negedge clk);
    @(posedge clk); #1; rst_n = 1'b1;
    chk("t5_partial_count", byte_q.size() - base, 3);
    base = byte_q.size();
    send(1, 32'h0000000F);
    wait_idle();
    chk_str("t5", base, "0000000F\r\n");
    chk("t5_grant", b.grant, 1);

    // DIGITS=2, NEWLINE=0 instance.
    @(posedge clk); #1;
    b2.req0_valid = 1'b1; b2.req0_data = 32'hFFFFFF9A;
    n = 0;
    do begin @(negedge clk); n++; end while (!b2.req0_ready && n < 50);
    chk("t6_ready", b2.req0_ready, 1);
    @(posedge clk); #1; b2.req0_valid = 1'b0; b2.req0_data = 32'h0;
    n = 0;
    do begin @(negedge clk); n++; end while (log2.size() < 2 && n < 50);
    chk("t6_busy_after_last", b2.busy, 0);
    chk("t6_tx_valid_after_last", b2.tx_valid, 0);
    repeat (3) @(negedge clk);
    chk("t6_count", log2.size(), 2);
    if (log2.size() >= 2) begin
      chk("t6_byte0", log2[0], 8'h39);
      chk("t6_byte1", log2[1], 8'h41);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hex_word_printer.md
# hex_word_printer

Sequencer and arbiter that turns 32-bit debug words from two requesters into a stream of uppercase hexadecimal ASCII characters for the debug UART transmitter. Each accepted word is emitted MSB nibble first, optionally followed by CR LF. The block sits between the core's debug taps (e.g. PC trace and register dump) and the UART TX byte interface. It owns the single nibble-to-ASCII conversion path and shares it round-robin between the two requesters.

## Interface
- `DIGITS`, default 8: hex digits printed per word, legal range 1..8; digit i is data bits [4i+3:4i].
- `NEWLINE`, default 1: 1 appends 0x0D, 0x0A after the digits; 0 emits digits only.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has a word to print.
- `req0_data` in 32: requester 0 word.
- `req0_ready` out 1: requester 0 word accepted this cycle when valid is also high.
- `req1_valid` in 1, `req1_data` in 32, `req1_ready` out 1: same as requester 0, for requester 1.
- `tx_valid` out 1: `tx_data` holds a byte for the UART.
- `tx_data` out 8: ASCII byte.
- `tx_ready` in 1: UART accepts the byte this cycle.
- `busy` out 1: a word is being emitted (state is not IDLE).
- `grant` out 1: index of the requester whose word is currently emitted; it holds its last value in IDLE.

## Operation
- **States.**
  - IDLE: arbitrate between requesters.
  - DIGIT: emit hex digits.
  - CR: emit 0x0D.
  - LF: emit 0x0A.
- **Arbitration in IDLE.** This logic is combinational from `reqN_valid` and the priority pointer `ptr`.
  - If exactly one requester is valid, that requester is selected.
  - If both are valid, requester `ptr` is selected.
  - `reqN_ready` is high only for the selected requester, and only in IDLE.
  - Both ready outputs are 0 in every other state.
- **On accept** (`valid & ready` in IDLE):
  - Capture the 32-bit word.
  - Set `grant` to the selected index.
  - Set `ptr` to the non-selected index.
  - Load the digit counter with `DIGITS-1`.
  - Go to DIGIT.
- **Digit conversion.**
  - Nibble values 0..9 map to 0x30..0x39.
  - Nibble values 10..15 map to 0x41..0x46.
  - The nibble emitted is word[4*cnt+3 : 4*cnt].
- **DIGIT state.**
  - On a byte accept with cnt > 0: decrement cnt.
  - On a byte accept with cnt = 0: go to CR if `NEWLINE`=1, otherwise go to IDLE.
- **CR state.** On a byte accept, go to LF.
- **LF state.** On a byte accept, go to IDLE.
- **Byte handshake.**
  - A byte is accepted when `tx_valid & tx_ready`.
  - While `tx_valid` is high and `tx_ready` is low, `tx_data` and the state are held stable.
  - `tx_valid` never drops without an accept, except on reset.
- **Request data.** Captured data is unaffected by later changes on `reqN_data`. A requester deasserting valid in a cycle where it was not accepted has no effect.

## Timing
- **Reset values** (asynchronous, while `rst_n`=0):
  - State IDLE.
  - `tx_valid`=0, `tx_data`=0x00.
  - `busy`=0, `grant`=0.
  - `ptr`=0, so requester 0 wins the first tie.
  - Captured word = 0, cnt = 0.
  - `reqN_ready` follows the IDLE arbitration combinationally once reset is released.
- **Reset mid-word.**
  - `tx_valid` drops immediately and the partial word is discarded.
  - The word is not resumed after reset is released.
- **Latency.** For an accept at edge N, `tx_valid` is high with the first digit from edge N+1 onward.
- **Throughput.**
  - With `tx_ready` held at 1, one byte is emitted per cycle.
  - A word takes `DIGITS` + 2·`NEWLINE` cycles.
  - It is followed by exactly one IDLE cycle before the next word's first byte appears at the earliest.
  - `tx_valid` is therefore low for one cycle between words.
- **Registered outputs.** `tx_data`, `tx_valid`, `busy` and `grant` are registered. Ready outputs are combinational.
- **Fairness.** With both requesters continuously valid, grants alternate 0,1,0,1...

## Test plan
- **Single word, no backpressure.** Apply reset, then req0 with data 0xDEADBEEF and `tx_ready`=1. The bytes must be 44 45 41 44 42 45 45 46 0D 0A on 10 consecutive cycles, the first one cycle after the accept. After the accept, `busy` stays 1 through the LF byte, then returns to 0.
- **Simultaneous requests after reset.** req0=0x00000001 and req1=0x0000ABCD, both valid. Requester 0 must be served first, then requester 1 with "0000ABCD\r\n". `grant` must read 0 then 1. `req1_ready` must stay low until requester 0's LF byte is accepted.
- **Backpressure.** Apply word 0x12345678. Hold `tx_ready`=0 for 3 cycles at the first byte and at the CR byte. `tx_data` must hold 0x31 and 0x0D respectively while stalled. The sequence must complete correctly with no byte lost or duplicated.
- **Continuous contention.** Both requesters are always valid with fixed words for 4 words. Grants must be 0,1,0,1. Exactly one `tx_valid`-low cycle must separate words.
- **Reset mid-operation.** Assert `rst_n`=0 during the 4th digit of 0xCAFEF00D. `tx_valid` must fall asynchronously and every reset value must be restored. After release, a new req1 word 0x0000000F prints "0000000F\r\n".
- **Parameter variant.** With `DIGITS`=2 and `NEWLINE`=0, word 0xFFFFFF9A must emit exactly 39 41. The block must return to IDLE after the 0x41 accept.
